// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO read-side blocks.
package fifo_pkg;

    localparam int unsigned FIFO_DSIZE = 8;
    localparam int unsigned FIFO_CNTW  = 16;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry prefetch buffer (head/tail) with push, pop and synchronous flush.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = FIFO_DSIZE
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [DSIZE-1:0] push_data_i,
    input  logic             pop_i,
    output occ_t             occ_o,
    output logic [DSIZE-1:0] head_o
);

    occ_t             occ_q, occ_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push_i) begin
                    head_d = push_data_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push_i && pop_i) begin
                    head_d = push_data_i;
                end else if (push_i) begin
                    tail_d = push_data_i;
                    occ_d  = OCC_FULL;
                end else if (pop_i) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // Push cannot arrive here: the producer is gated on occupancy.
                if (pop_i) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        if (flush_i) begin
            occ_d = OCC_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Async FIFO read-side consumer: turns the FIFO read port into a valid/ready stream
// through a 2-entry prefetch buffer, with flush and delivered/starved counters.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = FIFO_DSIZE,
    parameter int unsigned CNTW  = FIFO_CNTW
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [CNTW-1:0]  word_cnt,
    output logic [CNTW-1:0]  stall_cnt
);

    localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

    occ_t            occ;
    logic            pop;
    logic [CNTW-1:0] word_cnt_q, word_cnt_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    // No path from m_ready: fetch depends only on buffer state, rempty and flush.
    assign rinc    = ~rrst & ~flush & ~rempty & (occ != OCC_FULL);
    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;

    rd_skid_buf #(
        .DSIZE (DSIZE)
    ) u_buf (
        .clk_i       (rclk),
        .rst_i       (rrst),
        .flush_i     (flush),
        .push_i      (rinc),
        .push_data_i (rdata),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (m_data)
    );

    always_comb begin
        word_cnt_d  = word_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop) begin
            word_cnt_d = word_cnt_q + CntOne;
        end
        if (m_ready && !m_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized self-checking bench for fifo_rd_stream against a queue-based reference.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rrst = 1'b1;
    logic        rempty = 1'b1;
    logic [7:0]  rdata = 8'h00;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;
    logic        rinc, m_valid;
    logic [7:0]  m_data;
    logic [15:0] word_cnt, stall_cnt;
    logic        rinc4, m_valid4;
    logic [7:0]  m_data4;
    logic [3:0]  word_cnt4, stall_cnt4;

    int vecs = 0;
    int errs = 0;

    // Reference model: FIFO memory contents, prefetch buffer, counters, delivered words.
    logic [7:0] src[$];
    logic [7:0] mbuf[$];
    logic [7:0] obs[$];
    int         m_wc = 0;
    int         m_stall = 0;

    always #5 clk = ~clk;

    fifo_rd_stream dut (
        .rclk (clk), .rrst (rrst), .rempty (rempty), .rdata (rdata), .rinc (rinc),
        .flush (flush), .m_valid (m_valid), .m_data (m_data), .m_ready (m_ready),
        .word_cnt (word_cnt), .stall_cnt (stall_cnt)
    );

    fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut4 (
        .rclk (clk), .rrst (rrst), .rempty (rempty), .rdata (rdata), .rinc (rinc4),
        .flush (flush), .m_valid (m_valid4), .m_data (m_data4), .m_ready (m_ready),
        .word_cnt (word_cnt4), .stall_cnt (stall_cnt4)
    );

    function automatic logic e_rinc();
        return !rrst && !flush && !rempty && (mbuf.size() < 2);
    endfunction

    function automatic logic [15:0] e_st16();
        return (m_stall > 65535) ? 16'hFFFF : 16'(m_stall);
    endfunction

    function automatic logic [3:0] e_st4();
        return (m_stall > 15) ? 4'hF : 4'(m_stall);
    endfunction

    // Apply one cycle of inputs (called just after a falling edge).
    task automatic drive(input logic rst, input logic rdy, input logic fl, input logic hold);
        rrst    = rst;
        m_ready = rdy;
        flush   = fl;
        rempty  = hold || (src.size() == 0);
        rdata   = (src.size() != 0) ? src[0] : 8'($urandom);
        #1;
    endtask

    // Advance the reference model across the next rising edge, then move to the falling edge.
    task automatic advance();
        logic er, was_empty;
        er = e_rinc();
        if (m_valid && m_ready) obs.push_back(m_data);
        if (rrst) begin
            mbuf.delete();
            m_wc    = 0;
            m_stall = 0;
        end else begin
            was_empty = (mbuf.size() == 0);
            if (!was_empty && m_ready) begin
                void'(mbuf.pop_front());
                m_wc++;
            end
            if (er) mbuf.push_back(src.pop_front());
            if (flush) mbuf.delete();
            if (was_empty && m_ready) m_stall++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        src.delete();
        src.push_back(8'h55);
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            vecs++;
            if (rinc !== 1'b0) begin
                errs++; $display("FAIL reset_rinc: got %b expected 0", rinc);
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if ({m_valid, m_data, word_cnt, stall_cnt} !== 41'd0) begin
            errs++;
            $display("FAIL reset_state: got valid=%b data=%h wc=%h sc=%h expected all 0",
                     m_valid, m_data, word_cnt, stall_cnt);
        end
        vecs++;
        if ({m_valid4, word_cnt4, stall_cnt4} !== 9'd0) begin
            errs++;
            $display("FAIL reset_state4: got valid=%b wc=%h sc=%h expected all 0",
                     m_valid4, word_cnt4, stall_cnt4);
        end
        advance();
        src.delete();
    endtask

    task automatic test_stream4();
        logic [7:0] exp_w[4];
        int first_rinc, first_valid, last_valid;
        exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        first_rinc = -1; first_valid = -1; last_valid = -1;
        foreach (exp_w[i]) src.push_back(exp_w[i]);
        obs.delete();
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            if (rinc && first_rinc < 0) first_rinc = c;
            if (m_valid && first_valid < 0) first_valid = c;
            if (m_valid) last_valid = c;
            vecs++;
            if (rinc !== e_rinc()) begin
                errs++; $display("FAIL stream_rinc c%0d: got %b expected %b", c, rinc, e_rinc());
            end
            vecs++;
            if (m_valid !== (mbuf.size() != 0)) begin
                errs++; $display("FAIL stream_valid c%0d: got %b expected %b", c, m_valid,
                                 mbuf.size() != 0);
            end
            advance();
        end
        vecs++;
        if (first_valid != first_rinc + 1 || last_valid != first_valid + 3) begin
            errs++;
            $display("FAIL stream_latency: got rinc@%0d valid@%0d..%0d expected valid@%0d..%0d",
                     first_rinc, first_valid, last_valid, first_rinc + 1, first_rinc + 4);
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (obs.size() != 4 || obs[i] !== exp_w[i]) begin
                errs++; $display("FAIL stream_data[%0d]: got %h expected %h", i,
                                 (i < obs.size()) ? obs[i] : 8'hxx, exp_w[i]);
            end
        end
        vecs++;
        if (word_cnt !== 16'd4) begin
            errs++; $display("FAIL stream_word_cnt: got %0d expected 4", word_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w[3];
        int pulses;
        pulses = 0;
        foreach (w[i]) begin
            w[i] = 8'($urandom);
            src.push_back(w[i]);
        end
        obs.delete();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (rinc) pulses++;
            vecs++;
            if (rinc !== e_rinc()) begin
                errs++; $display("FAIL bp_rinc c%0d: got %b expected %b", c, rinc, e_rinc());
            end
            if (c >= 1) begin
                vecs++;
                if (m_valid !== 1'b1 || m_data !== w[0]) begin
                    errs++; $display("FAIL bp_hold c%0d: got v=%b d=%h expected v=1 d=%h",
                                     c, m_valid, m_data, w[0]);
                end
            end
            advance();
        end
        vecs++;
        if (pulses != 2) begin
            errs++; $display("FAIL bp_pulses: got %0d expected 2", pulses);
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (obs.size() != 3 || obs[i] !== w[i]) begin
                errs++; $display("FAIL bp_order[%0d]: got %h expected %h", i,
                                 (i < obs.size()) ? obs[i] : 8'hxx, w[i]);
            end
        end
    endtask

    task automatic test_alternate();
        logic [7:0] w[8];
        foreach (w[i]) begin
            w[i] = 8'($urandom);
            src.push_back(w[i]);
        end
        obs.delete();
        for (int c = 0; c < 30; c++) begin
            drive(1'b0, (c < 20) ? (c % 2 == 0) : 1'b1, 1'b0, 1'b0);
            vecs++;
            if (rinc !== e_rinc() || (rinc && mbuf.size() == 2)) begin
                errs++; $display("FAIL alt_rinc c%0d: got %b expected %b", c, rinc, e_rinc());
            end
            advance();
        end
        vecs++;
        if (obs.size() != 8) begin
            errs++; $display("FAIL alt_count: got %0d expected 8", obs.size());
        end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            vecs++;
            if (obs[i] !== w[i]) begin
                errs++; $display("FAIL alt_order[%0d]: got %h expected %h", i, obs[i], w[i]);
            end
        end
    endtask

    task automatic test_flush();
        src.push_back(8'hA0); src.push_back(8'hA1);
        src.push_back(8'hA2); src.push_back(8'hA3);
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        vecs++;
        if (rinc !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'hA0) begin
            errs++; $display("FAIL flush_cycle: got rinc=%b v=%b d=%h expected rinc=0 v=1 d=a0",
                             rinc, m_valid, m_data);
        end
        advance();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (m_valid !== 1'b0) begin
            errs++; $display("FAIL flush_empty: got valid=%b expected 0", m_valid);
        end
        advance();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (m_valid !== 1'b1 || m_data !== 8'hA2) begin
            errs++; $display("FAIL flush_next: got v=%b d=%h expected v=1 d=a2", m_valid, m_data);
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            advance();
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        advance();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            vecs++;
            if (rinc !== 1'b0) begin
                errs++; $display("FAIL stall_rinc c%0d: got %b expected 0", c, rinc);
            end
            advance();
            if (c == 9) begin
                vecs++;
                if (stall_cnt !== 16'd10 || stall_cnt4 !== 4'd10) begin
                    errs++; $display("FAIL stall_10: got %0d/%0d expected 10/10",
                                     stall_cnt, stall_cnt4);
                end
            end
        end
        vecs++;
        if (stall_cnt !== 16'd20 || stall_cnt4 !== 4'd15) begin
            errs++; $display("FAIL stall_sat: got %0d/%0d expected 20/15", stall_cnt, stall_cnt4);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) src.push_back(8'($urandom));
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            advance();
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            vecs++;
            if (rinc !== 1'b0) begin
                errs++; $display("FAIL rstmid_rinc c%0d: got %b expected 0", c, rinc);
            end
            advance();
            vecs++;
            if (m_valid !== 1'b0 || word_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
                errs++; $display("FAIL rstmid_state c%0d: got v=%b wc=%0d sc=%0d expected 0/0/0",
                                 c, m_valid, word_cnt, stall_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic rdy, fl, hold, rst;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(2) == 0) src.push_back(8'($urandom));
            rdy  = ($urandom_range(3) != 0);
            fl   = ($urandom_range(15) == 0);
            hold = ($urandom_range(7) == 0);
            rst  = ($urandom_range(127) == 0);
            drive(rst, rdy, fl, hold);
            vecs++;
            if (rinc !== e_rinc() || rinc4 !== e_rinc()) begin
                errs++; $display("FAIL rnd_rinc c%0d: got %b/%b expected %b", c, rinc, rinc4,
                                 e_rinc());
            end
            vecs++;
            if (m_valid !== (mbuf.size() != 0) || m_valid4 !== (mbuf.size() != 0)) begin
                errs++; $display("FAIL rnd_valid c%0d: got %b/%b expected %b", c, m_valid,
                                 m_valid4, mbuf.size() != 0);
            end
            if (mbuf.size() != 0) begin
                vecs++;
                if (m_data !== mbuf[0] || m_data4 !== mbuf[0]) begin
                    errs++; $display("FAIL rnd_data c%0d: got %h/%h expected %h", c, m_data,
                                     m_data4, mbuf[0]);
                end
            end
            vecs++;
            if (word_cnt !== 16'(m_wc) || word_cnt4 !== 4'(m_wc)) begin
                errs++; $display("FAIL rnd_word_cnt c%0d: got %0d/%0d expected %0d/%0d", c,
                                 word_cnt, word_cnt4, 16'(m_wc), 4'(m_wc));
            end
            vecs++;
            if (stall_cnt !== e_st16() || stall_cnt4 !== e_st4()) begin
                errs++; $display("FAIL rnd_stall_cnt c%0d: got %0d/%0d expected %0d/%0d", c,
                                 stall_cnt, stall_cnt4, e_st16(), e_st4());
            end
            advance();
        end
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_stream4();
        test_backpressure();
        test_alternate();
        test_flush();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer of the async FIFO, in the rclk domain, directly downstream of the read-pointer/empty logic and the FIFO memory.
- Converts the FIFO read port (rempty, rinc, combinational rdata at raddr) into a registered valid/ready stream through a 2-entry prefetch buffer.
- Provides synchronous flush and two status counters: words delivered and starved cycles.

Parameters:
- DSIZE, 8, data word width; matches FIFO memory width.
- CNTW, 16, width of status counters.

Ports:
- rclk  input  1  read-domain clock
- rrst  input  1  synchronous active-high reset
- rempty  input  1  registered empty flag from the read-pointer/empty stage
- rdata  input  DSIZE  FIFO memory read data, valid in the same cycle for the current raddr
- rinc  output  1  read-increment request to the read-pointer stage
- flush  input  1  synchronous flush of the prefetch buffer
- m_valid  output  1  stream valid
- m_data  output  DSIZE  stream data (head of buffer)
- m_ready  input  1  downstream ready
- word_cnt  output  CNTW  words accepted downstream; wraps
- stall_cnt  output  CNTW  cycles with m_ready=1 and m_valid=0; saturates

Behaviour:
- Single clock rclk. Reset is synchronous and active-high on rrst. No asynchronous reset.
- Reset values:
  - occ=0, m_valid=0, m_data=0, word_cnt=0, stall_cnt=0.
  - rinc=0 while rrst=1.
- Buffer: 2 entries, head and tail, with occupancy occ in {0,1,2}.
  - m_valid = (occ!=0).
  - m_data = head entry, held stable while m_valid=1 and m_ready=0.
- rinc = ~rrst & ~flush & ~rempty & (occ<2).
  - Purely a function of registered state, rempty and flush; no combinational path from m_ready.
- push = rinc. rdata is captured into the buffer on the same rclk edge that rinc is sampled.
- pop = m_valid & m_ready.
- occ_next = occ + push - pop.
  - Simultaneous push and pop at occ=1: head takes rdata, occ stays 1. This gives full throughput of 1 word/cycle.
  - Push at occ=2 never occurs because rinc is blocked.
  - Pop at occ=2 with no push: tail moves to head, occ becomes 1.
- Ordering is strict FIFO; no word is duplicated or dropped except by flush.
- Latency: a word present in FIFO memory with rempty=0 and occ=0 reaches m_valid=1 one cycle after rinc.
- flush=1:
  - rinc forced 0.
  - On the next edge occ=0 and m_valid=0; buffered words are discarded.
  - FIFO pointers are untouched.
  - A pop in the flush cycle still counts in word_cnt.
- word_cnt increments by 1 on every pop and wraps from 2^CNTW-1 to 0.
- stall_cnt increments when m_ready=1 and m_valid=0, and saturates at 2^CNTW-1.
- rempty rising while occ>0: buffered words still drain; no new rinc is issued.
- rrst mid-operation: buffered data is lost, outputs take their reset values on the next edge, and rinc is 0 during reset.

Decomposition:
- Shared package fifo_pkg holds:
  - the DSIZE default;
  - the occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2;
  - the counter-width default.
- One sub-module: rd_skid_buf, the 2-entry data/occupancy buffer with push/pop/flush.
- The top level holds the rinc generation and the status counters.

Test Plan:
- Reset then 4 words (0x11,0x22,0x33,0x44) preloaded, rempty=0, m_ready=1 -> m_data 0x11..0x44 on 4 consecutive cycles starting 1 cycle after the first rinc; word_cnt=4.
- m_ready=0 with 3 words available -> exactly 2 rinc pulses, occ=2, m_data=first word held stable; raise m_ready -> all 3 delivered in order.
- Alternating m_ready (1,0,1,0...) over 8 words -> no loss or duplication; rinc never asserted while occ=2.
- flush asserted with occ=2 (words 0xA0,0xA1) -> next cycle m_valid=0, rinc=0 during flush; next word after flush is 0xA2.
- rempty=1 and m_ready=1 for 10 cycles -> stall_cnt=10, rinc=0. With CNTW=4 and 20 cycles -> stall_cnt saturates at 15.
- rrst asserted with occ=2 mid-stream -> next edge m_valid=0, word_cnt=0, stall_cnt=0; rinc=0 for the whole reset.
